ptl_link_arbiter: RTL

Clocked scheduler that shares one passive-transmission-line (PTL) link between `N_REQ` requesters. A PTL receiver cell toggles its output once per arriving pulse and has a critical-timing window, 11.3 ps, after each pulse, during which a second pulse corrupts its output to X. This block serialises requests with round-robin fairness and drives the link in toggle encoding: one level change per pulse. It enforces a guard interval so that consecutive pulses never fall inside that window. It sits between the digital fabric and the PTL driver.

---
 rtl/ptl_link_arbiter_pkg.sv | 19 +
 rtl/ptl_link_arbiter_if.sv | 23 ++
 rtl/ptl_rr_picker.sv | 33 +++
 rtl/ptl_link_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/ptl_link_arbiter_pkg.sv
// Shared types and constants for the PTL link arbiter.
// Package ptl_arb_pkg: FSM state enum, default parameters and a counter-width helper.
package ptl_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GUARD = 1'b1
  } arb_state_e;

  localparam int DEF_N_REQ        = 4;
  localparam int DEF_GAP_CYCLES   = 3;
  localparam int DEF_ECHO_TIMEOUT = 8;

  // Bits needed for a down-counter that is loaded with max_val; never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ptl_link_arbiter_if.sv
// Requester / PTL link bundle between the digital fabric (master) and the arbiter (slave).
interface ptl_link_arbiter_if #(
  parameter int N_REQ = ptl_arb_pkg::DEF_N_REQ
);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             tx_line;
  logic             busy;
  logic             rx_echo;
  logic             err;

  modport master (
    output req, rx_echo,
    input  gnt, tx_line, busy, err
  );

  modport slave (
    input  req, rx_echo,
    output gnt, tx_line, busy, err
  );

endinterface

// File: rtl/ptl_rr_picker.sv
// Combinational round-robin search: first asserted request above ptr_i, wrapping.
module ptl_rr_picker #(
  parameter int N_REQ = ptl_arb_pkg::DEF_N_REQ,
  localparam int PW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic             any_o,
  output logic [PW-1:0]    win_idx_o,
  output logic [N_REQ-1:0] win_onehot_o
);

  logic [PW-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves a latch.
    cand         = '0;
    win_idx_o    = '0;
    win_onehot_o = '0;
    any_o        = |req_i;
    // Walk from the furthest offset to the nearest so the closest hit is written last.
    for (int off = N_REQ; off >= 1; off--) begin
      cand = PW'((int'(ptr_i) + off) % N_REQ);
      if (req_i[cand]) begin
        win_idx_o = cand;
      end
    end
    if (any_o) begin
      win_onehot_o[win_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/ptl_link_arbiter.sv
// Round-robin toggle-encoded PTL link driver with a guard interval between pulses.
// Optional receiver echo checker compiled in with `define PTL_ARB_ECHO_CHECK_EN.
module ptl_link_arbiter
  import ptl_arb_pkg::*;
#(
  parameter int N_REQ        = DEF_N_REQ,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int ECHO_TIMEOUT = DEF_ECHO_TIMEOUT
) (
  input logic               clk,
  input logic               rst,
  ptl_link_arbiter_if.slave bus
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = cnt_width(GAP_CYCLES);

  if (N_REQ < 2 || GAP_CYCLES < 1 || ECHO_TIMEOUT < 1) begin : g_bad_param
    $error("ptl_link_arbiter: N_REQ>=2, GAP_CYCLES>=1 and ECHO_TIMEOUT>=1 are required");
  end

  arb_state_e       state_q;
  logic             tx_q;
  logic             busy_q;
  logic [N_REQ-1:0] gnt_q;
  logic [PW-1:0]    ptr_q;
  logic [CW-1:0]    cnt_q;

  logic             any_req;
  logic [PW-1:0]    win_idx;
  logic [N_REQ-1:0] win_onehot;
  logic             launch;

  ptl_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req_i        (bus.req),
    .ptr_i        (ptr_q),
    .any_o        (any_req),
    .win_idx_o    (win_idx),
    .win_onehot_o (win_onehot)
  );

  assign launch = (state_q == IDLE) && any_req;

  // Pointer resets to the last requester so requester 0 has first claim on the link.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b0;
      busy_q  <= 1'b0;
      gnt_q   <= '0;
      ptr_q   <= PW'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      gnt_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            tx_q    <= ~tx_q;
            gnt_q   <= win_onehot;
            ptr_q   <= win_idx;
            cnt_q   <= CW'(GAP_CYCLES);
            busy_q  <= 1'b1;
            state_q <= GUARD;
          end
        end
        GUARD: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.tx_line = tx_q;
  assign bus.busy    = busy_q;

`ifdef PTL_ARB_ECHO_CHECK_EN
  localparam int EW = cnt_width(ECHO_TIMEOUT);

  logic [EW-1:0] echo_q;
  logic          rx_prev_q;
  logic          err_q;

  // A running timer stops once the echo matches; only an idle timer treats echo edges as spurious.
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_q    <= '0;
      rx_prev_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_prev_q <= bus.rx_echo;
      if (launch) begin
        echo_q <= EW'(ECHO_TIMEOUT);
      end else if (echo_q != '0) begin
        if (bus.rx_echo == tx_q) begin
          echo_q <= '0;
        end else begin
          echo_q <= echo_q - 1'b1;
          if (echo_q == EW'(1)) begin
            err_q <= 1'b1;
          end
        end
      end else if (bus.rx_echo != rx_prev_q && bus.rx_echo != tx_q) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
